// File: rtl/bk_adder_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// bk_arb_pkg
// Shared definitions for the time-shared Brent-Kung adder arbiter:
//   BK_WIDTH    - operand width of the adder core (fixed at 12)
//   MAX_REQ     - largest supported requester count
//   arb_state_t - arbiter FSM states (IDLE, EXEC, RESP)
//   bk_word_t   - one adder operand / result word
//   rr_pick     - round-robin winner search returning {found, idx}
// ---------------------------------------------------------------------------
package bk_arb_pkg;

   localparam int BK_WIDTH = 12;
   localparam int MAX_REQ  = 8;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

   typedef logic [BK_WIDTH-1:0] bk_word_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Search upward from ptr+1 (wrapping at nreq) and return the first
   // requester whose bit is set. The request vector is zero-padded to
   // MAX_REQ so one function serves every legal NREQ.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         ptr,
                                        input int                 nreq);
      rr_pick_t res;
      int       cand;
      res.found = 1'b0;
      res.idx   = '0;
      cand      = 0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= nreq && !res.found) begin
            cand = (int'(ptr) + k) % nreq;
            if (req[cand[2:0]]) begin
               res.found = 1'b1;
               res.idx   = cand[2:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bk_adder_share_arb_if.sv
// ---------------------------------------------------------------------------
// bk_adder_share_arb_if
// Bundles the request and response channels of the shared adder arbiter.
//   req_valid/req_ready - per-requester handshake (NREQ bits each)
//   req_a/req_b         - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready - shared response handshake
//   rsp_id/sum/cout     - owner of the result, sum and carry out
//   busy                - arbiter is not idle
// Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface bk_adder_share_arb_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 12,
   parameter int IDW   = $clog2(NREQ)
) ();

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

endinterface

// File: rtl/bk_adder_share_arb_core.sv
// ---------------------------------------------------------------------------
// bk_add12_core
// Purely combinational 12-bit adder built as a Brent-Kung parallel prefix
// tree: an up-sweep forms power-of-two group carries, a down-sweep fills in
// the remaining positions.
//   a, b  - operands
//   sum   - a+b truncated to 12 bits
//   cout  - carry out of bit 11
// ---------------------------------------------------------------------------
module bk_add12_core
   import bk_arb_pkg::*;
(
   input  bk_word_t a,
   input  bk_word_t b,
   output bk_word_t sum,
   output logic     cout
);

   localparam int TOP_STEP = 2 ** ($clog2(BK_WIDTH) - 1);

   bk_word_t gen;
   bk_word_t prop;
   bk_word_t grp_g;
   bk_word_t grp_p;

   // grp_g[i]/grp_p[i] start as per-bit generate/propagate and are merged
   // in place. Within one level the positions written never overlap the
   // positions read, so the in-place update is a true parallel level.
   // After both sweeps grp_g[i] is the carry out of bits [i:0].
   always_comb begin
      gen   = a & b;
      prop  = a ^ b;
      grp_g = gen;
      grp_p = prop;

      for (int step = 1; step < BK_WIDTH; step = step * 2) begin
         for (int i = 2 * step - 1; i < BK_WIDTH; i = i + 2 * step) begin
            grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-step]);
            grp_p[i] = grp_p[i] & grp_p[i-step];
         end
      end

      for (int step = TOP_STEP; step >= 1; step = step / 2) begin
         for (int i = 3 * step - 1; i < BK_WIDTH; i = i + 2 * step) begin
            grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-step]);
            grp_p[i] = grp_p[i] & grp_p[i-step];
         end
      end

      sum = prop;
      for (int i = 1; i < BK_WIDTH; i++) begin
         sum[i] = prop[i] ^ grp_g[i-1];
      end
      cout = grp_g[BK_WIDTH-1];
   end

endmodule

// File: rtl/bk_adder_share_arb.sv
// ---------------------------------------------------------------------------
// bk_adder_share_arb
// Time-shares a single bk_add12_core among NREQ requesters. A round-robin
// arbiter accepts one request in IDLE, the registered operands are added in
// EXEC, and the registered result is held in RESP until the consumer takes
// it. One operation completes every 3 cycles with rsp_ready held high.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - bk_adder_share_arb_if.slave (request/response channels, busy)
// Optional build macro BK_ARB_SAT_EN: saturate rsp_sum to all ones when the
// addition carries out; rsp_cout still reports the true carry.
// ---------------------------------------------------------------------------
module bk_adder_share_arb
   import bk_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 12,
   parameter int IDW   = $clog2(NREQ)
) (
   input logic                clk,
   input logic                rst_n,
   bk_adder_share_arb_if.slave bus
);

   if (WIDTH != BK_WIDTH) begin : g_width_chk
      $error("bk_adder_share_arb: WIDTH must equal BK_WIDTH (12)");
   end
   if (NREQ < 2 || NREQ > MAX_REQ) begin : g_nreq_chk
      $error("bk_adder_share_arb: NREQ must be in 2..8");
   end
   if (IDW != $clog2(NREQ)) begin : g_idw_chk
      $error("bk_adder_share_arb: IDW must equal $clog2(NREQ)");
   end

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [IDW-1:0]      rr_ptr;
   logic [IDW-1:0]      op_id;
   logic [IDW-1:0]      win_id;
   bk_word_t            op_a;
   bk_word_t            op_b;
   bk_word_t            sel_a;
   bk_word_t            sel_b;
   bk_word_t            core_sum;
   bk_word_t            result_sum;
   logic                core_cout;
   logic [MAX_REQ-1:0]  req_pad;
   rr_pick_t            pick;
   logic [NREQ-1:0]     grant;
   logic                accept;
   logic                rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   bk_word_t            rsp_sum_q;
   logic                rsp_cout_q;

   // Round-robin winner search and a mux that selects the winner's
   // operands; only consumed when a grant is actually issued from IDLE.
   always_comb begin
      req_pad           = '0;
      req_pad[NREQ-1:0] = bus.req_valid;
      pick              = rr_pick(req_pad, 3'(rr_ptr), NREQ);
      win_id            = pick.idx[IDW-1:0];
      sel_a             = bus.req_a[pick.idx*WIDTH +: WIDTH];
      sel_b             = bus.req_b[pick.idx*WIDTH +: WIDTH];
   end

   // Next-state and grant decode. A grant is only possible in IDLE, which
   // guarantees a request seen during the response handshake waits until
   // the following cycle.
   always_comb begin
      state_nxt = state;
      grant     = '0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick.found) begin
               grant     = {{(NREQ-1){1'b0}}, 1'b1} << pick.idx;
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture on the accept edge. rr_ptr resets to NREQ-1 so the
   // first search after reset begins at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= IDW'(NREQ - 1);
         op_a   <= '0;
         op_b   <= '0;
         op_id  <= '0;
      end else if (accept) begin
         rr_ptr <= win_id;
         op_a   <= sel_a;
         op_b   <= sel_b;
         op_id  <= win_id;
      end
   end

   bk_add12_core u_core (
      .a    (op_a),
      .b    (op_b),
      .sum  (core_sum),
      .cout (core_cout)
   );

`ifdef BK_ARB_SAT_EN
   assign result_sum = core_cout ? {BK_WIDTH{1'b1}} : core_sum;
`else
   assign result_sum = core_sum;
`endif

   // Response register: loaded at the end of EXEC, held through RESP, and
   // the valid flag is dropped on the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else if (state == EXEC) begin
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= op_id;
         rsp_sum_q   <= result_sum;
         rsp_cout_q  <= core_cout;
      end else if (state == RESP && bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // req_ready is gated by rst_n so no grant escapes while reset is held.
   assign bus.req_ready = rst_n ? grant : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_bk_adder_share_arb.sv
// ---------------------------------------------------------------------------
// tb_bk_adder_share_arb
// Directed bench for bk_adder_share_arb: a table of single-request vectors
// followed by hand-written round-robin, backpressure, reset-in-EXEC and
// fairness sequences. Honors BK_ARB_SAT_EN when computing expected sums.
// ---------------------------------------------------------------------------
module tb_bk_adder_share_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 12;
   localparam int IDW   = 2;
   localparam int NVEC  = 10;

   typedef struct {
      int          id;
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] exp_sum;
      logic        exp_cout;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   pass_count  = 0;
   int   check_count = 0;

   vec_t        vecs[NVEC];
   logic [11:0] tb_a[NREQ];
   logic [11:0] tb_b[NREQ];
   int          exp_seq[8];

   bk_adder_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   bk_adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [11:0] adj_sum(input logic [11:0] s, input logic c);
`ifdef BK_ARB_SAT_EN
      return c ? 12'hFFF : s;
`else
      return (c === 1'b1) ? s : s;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus(input int id, input logic [11:0] a, input logic [11:0] b);
      bus.req_a[id*12 +: 12] = a;
      bus.req_b[id*12 +: 12] = b;
      bus.req_valid[id]      = 1'b1;
      tb_a[id]               = a;
      tb_b[id]               = b;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Bounded wait for the next grant; returns -1 on timeout.
   task automatic waitGrant(output int idx, output int at);
      idx = -1;
      at  = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            checkOutput("grant onehot", 32'($onehot(bus.req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
            at = cyc;
            break;
         end
      end
      if (idx == -1) checkOutput("grant timeout", 32'd0, 32'd1);
   endtask

   // Requests held continuously with rsp_ready=1; checks grant order,
   // 3-cycle spacing and each response against the bench's own sum.
   task automatic runSeq(input int n);
      int          idx;
      int          at;
      int          last_at;
      logic [12:0] full;
      last_at = 0;
      for (int k = 0; k < n; k++) begin
         waitGrant(idx, at);
         checkOutput($sformatf("seq%0d grant id", k), 32'(idx), 32'(exp_seq[k]));
         if (k > 0) checkOutput($sformatf("seq%0d spacing", k), 32'(at - last_at), 32'd3);
         last_at = at;
         @(negedge clk);
         @(negedge clk);
         full = {1'b0, tb_a[exp_seq[k]]} + {1'b0, tb_b[exp_seq[k]]};
         checkOutput($sformatf("seq%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
         checkOutput($sformatf("seq%0d rsp_id", k), 32'(bus.rsp_id), 32'(exp_seq[k]));
         checkOutput($sformatf("seq%0d rsp_sum", k), 32'(bus.rsp_sum), 32'(adj_sum(full[11:0], full[12])));
      end
   endtask

   initial begin
      vecs[0] = '{1, 12'h0FF, 12'h001, 12'h100, 1'b0};
      vecs[1] = '{0, 12'hFFF, 12'h001, 12'h000, 1'b1};
      vecs[2] = '{2, 12'h555, 12'hAAA, 12'hFFF, 1'b0};
      vecs[3] = '{3, 12'h800, 12'h800, 12'h000, 1'b1};
      vecs[4] = '{0, 12'h123, 12'h456, 12'h579, 1'b0};
      vecs[5] = '{2, 12'hABC, 12'h678, 12'h134, 1'b1};
      vecs[6] = '{3, 12'h000, 12'h000, 12'h000, 1'b0};
      vecs[7] = '{1, 12'h7FF, 12'h801, 12'h000, 1'b1};
      vecs[8] = '{0, 12'hF0F, 12'h0F1, 12'h000, 1'b1};
      vecs[9] = '{1, 12'h3A5, 12'h1C7, 12'h56C, 1'b0};

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      #1;
      rst_n = 1'b0;

      // Reset values, with every requester asking for service.
      bus.req_valid = '1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
         checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
         checkOutput("reset rsp_id", 32'(bus.rsp_id), 32'd0);
         checkOutput("reset rsp_sum", 32'(bus.rsp_sum), 32'd0);
         checkOutput("reset rsp_cout", 32'(bus.rsp_cout), 32'd0);
         checkOutput("reset busy", 32'(bus.busy), 32'd0);
      end
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.req_valid = '0;

      // Table of single requests: grant, EXEC, then response two cycles on.
      for (int v = 0; v < NVEC; v++) begin
         @(posedge clk); #1;
         bus.req_valid = '0;
         applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b);
         @(negedge clk);
         checkOutput($sformatf("vec%0d req_ready", v), 32'(bus.req_ready), 32'd1 << vecs[v].id);
         checkOutput($sformatf("vec%0d idle busy", v), 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
         bus.req_valid = '0;
         @(negedge clk);
         checkOutput($sformatf("vec%0d exec ready", v), 32'(bus.req_ready), 32'd0);
         checkOutput($sformatf("vec%0d exec valid", v), 32'(bus.rsp_valid), 32'd0);
         checkOutput($sformatf("vec%0d exec busy", v), 32'(bus.busy), 32'd1);
         @(negedge clk);
         checkOutput($sformatf("vec%0d rsp_valid", v), 32'(bus.rsp_valid), 32'd1);
         checkOutput($sformatf("vec%0d rsp_id", v), 32'(bus.rsp_id), 32'(vecs[v].id));
         checkOutput($sformatf("vec%0d rsp_sum", v), 32'(bus.rsp_sum),
                     32'(adj_sum(vecs[v].exp_sum, vecs[v].exp_cout)));
         checkOutput($sformatf("vec%0d rsp_cout", v), 32'(bus.rsp_cout), 32'(vecs[v].exp_cout));
      end

      // All four requesters continuously valid after a reset.
      doReset();
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 12'(12'h100 * i + 12'h0F0), 12'h020);
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2;
      exp_seq[3] = 3; exp_seq[4] = 0; exp_seq[5] = 1;
      runSeq(6);
      @(posedge clk); #1;
      bus.req_valid = '0;

      // Backpressure: result held for several cycles, requester 0 waiting.
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      applyStimulus(2, 12'h234, 12'h111);
      @(negedge clk);
      checkOutput("bp grant", 32'(bus.req_ready), 32'b0100);
      @(posedge clk); #1;
      bus.req_valid = '0;
      applyStimulus(0, 12'h001, 12'h002);
      @(negedge clk);
      checkOutput("bp exec ready", 32'(bus.req_ready), 32'd0);
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         checkOutput($sformatf("bp%0d rsp_valid", n), 32'(bus.rsp_valid), 32'd1);
         checkOutput($sformatf("bp%0d rsp_sum", n), 32'(bus.rsp_sum), 32'h345);
         checkOutput($sformatf("bp%0d rsp_id", n), 32'(bus.rsp_id), 32'd2);
         checkOutput($sformatf("bp%0d req_ready", n), 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp handshake ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp handshake valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      checkOutput("bp regrant", 32'(bus.req_ready), 32'b0001);
      checkOutput("bp idle valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("bp idle busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp2 rsp_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("bp2 rsp_sum", 32'(bus.rsp_sum), 32'h003);

      // Reset while 0x800+0x800 is in EXEC; the result must never appear.
      @(posedge clk); #1;
      applyStimulus(3, 12'h800, 12'h800);
      @(negedge clk);
      checkOutput("rst grant", 32'(bus.req_ready), 32'b1000);
      @(posedge clk); #1;
      bus.req_valid = '0;
      #2;
      applyStimulus(1, 12'h0AA, 12'h011);
      applyStimulus(2, 12'h0F0, 12'h00F);
      checkOutput("rst pre busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst async busy", 32'(bus.busy), 32'd0);
      checkOutput("rst async valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst async sum", 32'(bus.rsp_sum), 32'd0);
      checkOutput("rst async cout", 32'(bus.rsp_cout), 32'd0);
      checkOutput("rst async ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      checkOutput("rst held ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst held valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst restart grant", 32'(bus.req_ready), 32'b0010);
      checkOutput("rst restart valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      checkOutput("rst exec valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput("rst rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("rst rsp_id", 32'(bus.rsp_id), 32'd1);
      checkOutput("rst rsp_sum", 32'(bus.rsp_sum), 32'h0BB);
      checkOutput("rst rsp_cout", 32'(bus.rsp_cout), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = '0;

      // Fairness: requesters 0 and 3 alternate.
      doReset();
      applyStimulus(0, 12'h00F, 12'h001);
      applyStimulus(3, 12'hE00, 12'h0FF);
      exp_seq[0] = 0; exp_seq[1] = 3; exp_seq[2] = 0;
      exp_seq[3] = 3; exp_seq[4] = 0; exp_seq[5] = 3;
      runSeq(6);
      @(posedge clk); #1;
      bus.req_valid = '0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/bk_adder_share_arb.md
Name: bk_adder_share_arb

Overview:
- Time-shares one combinational 12-bit Brent-Kung adder core among NREQ requesters.
- Per-requester valid/ready request channels; a single shared response channel.
- Round-robin arbitration, registered operands, registered result.
- Sits between the datapath clients and the adder core, so the core is never duplicated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 12, operand width; fixed by the adder core, checked by elaboration assertion.
- IDW, 2, response id width, equal to $clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B; same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  sum, A+B mod 2^WIDTH.
- rsp_cout  out  1  carry out of the addition.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, state=IDLE, rr_ptr=NREQ-1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr+1 (mod NREQ).
  - req_ready[winner]=1 combinationally in that cycle; no other ready bit is high.
  - On the clock edge the block captures A and B into op_a/op_b, captures the winner into op_id, sets rr_ptr=winner, and moves to EXEC.
- EXEC:
  - The core evaluates op_a+op_b.
  - On the clock edge the block registers rsp_sum, rsp_cout and rsp_id, sets rsp_valid=1, and moves to RESP.
- RESP:
  - rsp_valid and the result fields hold stable while rsp_ready=0.
  - On rsp_valid&rsp_ready the block clears rsp_valid and returns to IDLE.
  - The next grant can come no earlier than the cycle after the response handshake.
- Latency: the accept edge is T; rsp_valid is first high in cycle T+2.
- Throughput: one operation per 3 cycles when rsp_ready is held high.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and data until accepted. A requester that drops valid before acceptance is simply not granted; this is legal.
- Simultaneous events: a request arriving in the same cycle as the response handshake is not granted until the following cycle, from IDLE.
- Fairness: a continuously requesting client waits at most NREQ-1 other grants.
- Reset mid-operation: asserting rst_n=0 in any state returns the block to reset values immediately, and the in-flight result is discarded. On release, arbitration restarts from requester 0.
- Width rules: the sum is truncated to WIDTH bits and the carry is reported separately. No sign interpretation.

Optional Feature:
- Macro: BK_ARB_SAT_EN.
- Defined: when the core carry is 1, rsp_sum=all ones ({WIDTH{1'b1}}); rsp_cout still reports the true carry.
- Undefined: rsp_sum is the modular sum; no saturation logic is synthesized.

Decomposition:
- Package bk_arb_pkg:
  - BK_WIDTH=12;
  - state enum typedef arb_state_t {IDLE, EXEC, RESP};
  - typedef bk_word_t logic [BK_WIDTH-1:0];
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- Sub-module bk_add12_core: purely combinational a+b -> {cout, sum}, Brent-Kung prefix structure. It is instantiated exactly once, on op_a/op_b.

Test Plan:
- Single request, requester 1: A=0x0FF, B=0x001 -> req_ready[1] high for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_sum=0x100, rsp_cout=0.
- Overflow: A=0xFFF, B=0x001 on requester 0 -> rsp_sum=0x000, rsp_cout=1; with BK_ARB_SAT_EN, rsp_sum=0xFFF, rsp_cout=1.
- All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; each grant 3 cycles apart; never two ready bits in one cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_sum/rsp_id stable; no req_ready pulse; grant occurs the cycle after rsp_ready=1 returns to IDLE.
- Reset in EXEC with A=0x800, B=0x800 in flight -> all outputs 0 asynchronously; after release, no response ever appears for the lost op; next grant goes to the lowest-index valid requester.
- Fairness: requesters 0 and 3 valid continuously, 1 and 2 idle -> ids alternate 3,0,3,0 after the first grant to 0.
